// File: rtl/threshold_refractory_unit.sv
// Time-multiplexed threshold/refractory stage: one (neuron, potential) sample per cycle,
// per-neuron refractory counters, selectable reset mode and a registered output stage.
module threshold_refractory_unit #(
    parameter int INTEGER_WIDTH   = 8,
    parameter int DATA_WIDTH_FRAC = 0,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NUM_NEURONS     = 16,
    parameter int IDX_WIDTH       = $clog2(NUM_NEURONS),
    parameter int REF_WIDTH       = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] vth,
    input  logic                         reset_mode,
    input  logic        [REF_WIDTH-1:0]  ref_period,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic        [IDX_WIDTH-1:0]  in_idx,
    input  logic signed [DATA_WIDTH-1:0] in_vmem,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [IDX_WIDTH-1:0]  out_idx,
    output logic signed [DATA_WIDTH-1:0] vmem_out,
    output logic                         spike_out,
    input  logic                         cnt_clear,
    output logic        [CNT_WIDTH-1:0]  spike_count
);

    localparam logic [IDX_WIDTH:0] NUM_N_L = (IDX_WIDTH + 1)'(NUM_NEURONS);

    // Subtract at one extra bit, then clamp to the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_sub(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] d;
        d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
            if (d[DATA_WIDTH]) begin
                sat_sub = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                sat_sub = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_sub = d[DATA_WIDTH-1:0];
        end
    endfunction

    logic        [REF_WIDTH-1:0]  r_ref_cnt [NUM_NEURONS];
    logic                         r_out_valid;
    logic        [IDX_WIDTH-1:0]  r_out_idx;
    logic signed [DATA_WIDTH-1:0] r_vmem_out;
    logic                         r_spike_out;
    logic        [CNT_WIDTH-1:0]  r_spike_count;

    logic                         w_accept;
    logic                         w_in_range;
    logic        [REF_WIDTH-1:0]  w_ref_cur;
    logic                         w_refr;
    logic                         w_fire;
    logic signed [DATA_WIDTH-1:0] w_vmem_next;
    logic                         w_spk_acc;

    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_in_range  = ({1'b0, in_idx} < NUM_N_L);
    assign w_refr      = w_in_range && (w_ref_cur != '0);
    assign w_fire      = w_in_range && !w_refr && (in_vmem >= vth);
    assign w_spk_acc   = w_accept && w_fire;

    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign vmem_out    = r_vmem_out;
    assign spike_out   = r_spike_out;
    assign spike_count = r_spike_count;

    // Select the refractory counter of the addressed neuron.
    always_comb begin
        w_ref_cur = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (IDX_WIDTH'(k) == in_idx) begin
                w_ref_cur = r_ref_cnt[k];
            end else begin
                w_ref_cur = w_ref_cur;
            end
        end
    end

    // Updated potential in decision priority order.
    always_comb begin
        w_vmem_next = in_vmem;
        if (!w_in_range) begin
            w_vmem_next = in_vmem;
        end else if (w_refr) begin
            w_vmem_next = '0;
        end else if (w_fire) begin
            if (reset_mode) begin
                w_vmem_next = sat_sub(in_vmem, vth);
            end else begin
                w_vmem_next = '0;
            end
        end else begin
            w_vmem_next = in_vmem;
        end
    end

    // Refractory counters change only when their own neuron is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_ref_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (w_accept && w_in_range && (in_idx == IDX_WIDTH'(k))) begin
                    if (w_refr) begin
                        r_ref_cnt[k] <= r_ref_cnt[k] - REF_WIDTH'(1);
                    end else if (w_fire) begin
                        r_ref_cnt[k] <= ref_period;
                    end else begin
                        r_ref_cnt[k] <= r_ref_cnt[k];
                    end
                end else begin
                    r_ref_cnt[k] <= r_ref_cnt[k];
                end
            end
        end
    end

    // Output register: load on accept, hold while stalled, drop after hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_vmem_out  <= '0;
            r_spike_out <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= in_idx;
            r_vmem_out  <= w_vmem_next;
            r_spike_out <= w_fire;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Saturating spike counter; a clear coinciding with a spike leaves one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_count <= '0;
        end else if (cnt_clear) begin
            r_spike_count <= w_spk_acc ? CNT_WIDTH'(1) : CNT_WIDTH'(0);
        end else if (w_spk_acc && (r_spike_count != '1)) begin
            r_spike_count <= r_spike_count + CNT_WIDTH'(1);
        end else begin
            r_spike_count <= r_spike_count;
        end
    end

endmodule

// File: tb/tb_threshold_refractory_unit.sv
// Scoreboard bench for threshold_refractory_unit (10 neurons, 4-bit spike counter).
module tb_threshold_refractory_unit;

    localparam int NN   = 10;
    localparam int CMAX = 15;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] vth;
    logic              reset_mode;
    logic        [3:0] ref_period;
    logic              in_valid;
    logic              in_ready;
    logic        [3:0] in_idx;
    logic signed [7:0] in_vmem;
    logic              out_valid;
    logic              out_ready;
    logic        [3:0] out_idx;
    logic signed [7:0] vmem_out;
    logic              spike_out;
    logic              cnt_clear;
    logic        [3:0] spike_count;

    int          total = 0;
    int          bad   = 0;
    int          m_ref [NN];
    int          m_cnt = 0;
    logic [12:0] sbq [$];

    threshold_refractory_unit #(
        .INTEGER_WIDTH(8), .DATA_WIDTH_FRAC(0), .NUM_NEURONS(NN),
        .REF_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vth(vth), .reset_mode(reset_mode),
        .ref_period(ref_period), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_vmem(in_vmem), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .vmem_out(vmem_out),
        .spike_out(spike_out), .cnt_clear(cnt_clear), .spike_count(spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: check outputs on the falling edge, model any accept, return just after the rising edge.
    task automatic tick();
        int vm, vt, vo, idx;
        bit spk;
        @(negedge clk);
        total++;
        if (spike_count !== 4'(m_cnt)) begin
            bad++;
            $display("FAIL cnt: got %0d expected %0d", spike_count, m_cnt);
        end
        total++;
        if (in_ready !== (!out_valid || out_ready)) begin
            bad++;
            $display("FAIL in_ready: got %0b with out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready);
        end
        if (out_valid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: idx=%0d vmem=%0d spike=%0b with empty scoreboard", out_idx, vmem_out, spike_out);
            end else begin
                if ({out_idx, vmem_out, spike_out} !== sbq[0]) begin
                    bad++;
                    $display("FAIL out: got idx=%0d vmem=%0d spike=%0b expected idx=%0d vmem=%0d spike=%0b",
                             out_idx, vmem_out, spike_out, sbq[0][12:9], $signed(sbq[0][8:1]), sbq[0][0]);
                end
                if (out_ready) void'(sbq.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            idx = int'(in_idx);
            vm  = int'(in_vmem);
            vt  = int'(vth);
            spk = 1'b0;
            vo  = vm;
            if (idx >= NN) begin
                vo = vm;
            end else if (m_ref[idx] != 0) begin
                vo = 0;
                m_ref[idx]--;
            end else if (vm >= vt) begin
                spk = 1'b1;
                m_ref[idx] = int'(ref_period);
                if (reset_mode) begin
                    vo = vm - vt;
                    if (vo > 127) vo = 127;
                    if (vo < -128) vo = -128;
                end else begin
                    vo = 0;
                end
            end
            sbq.push_back({4'(idx), 8'(vo), spk});
            if (cnt_clear) m_cnt = spk ? 1 : 0;
            else if (spk && m_cnt < CMAX) m_cnt++;
        end else if (cnt_clear) begin
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input int vm);
        in_valid = 1'b1;
        in_idx   = 4'(idx);
        in_vmem  = 8'(vm);
    endtask

    task automatic send(input int idx, input int vm);
        drive(idx, vm);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic setcfg(input int t, input bit mode, input int rp);
        vth        = 8'(t);
        reset_mode = mode;
        ref_period = 4'(rp);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({out_valid, out_idx, vmem_out, spike_out, spike_count} !== 18'd0) begin
            bad++;
            $display("FAIL reset_state: got ov=%0b idx=%0d vmem=%0d spk=%0b cnt=%0d expected all zero",
                     out_valid, out_idx, vmem_out, spike_out, spike_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %0b expected 1", in_ready);
        end
        idle(2);
    endtask

    task automatic test_basic();
        setcfg(40, 1'b0, 0);
        send(3, 50);
        idle(1);
        total++;
        if (spike_count !== 4'd1) begin
            bad++;
            $display("FAIL basic_cnt: got %0d expected 1", spike_count);
        end
        send(4, 10);
        send(4, -20);
        idle(2);
    endtask

    task automatic test_mode1();
        setcfg(40, 1'b1, 0);
        send(1, 100);
        setcfg(-100, 1'b1, 0);
        send(1, 100);
        setcfg(100, 1'b1, 0);
        send(2, -100);
        setcfg(-100, 1'b1, 0);
        send(2, -128);
        idle(2);
    endtask

    task automatic test_refractory();
        setcfg(40, 1'b0, 2);
        send(5, 50);
        send(6, 10);
        send(5, 120);
        send(6, 50);
        send(5, 120);
        send(5, 120);
        send(6, 120);
        send(6, 120);
        send(6, 120);
        idle(2);
    endtask

    task automatic test_backpressure();
        setcfg(20, 1'b0, 0);
        out_ready = 1'b0;
        send(7, 30);
        drive(8, 60);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready: got %0b expected 0 at stall cycle %0d", in_ready, i);
            end
            if (i == 1) vth = 8'sd100;
            tick();
        end
        out_ready = 1'b1;
        tick();
        send(9, 110);
        send(0, 99);
        send(1, 101);
        idle(3);
    endtask

    task automatic test_boundaries();
        setcfg(40, 1'b0, 0);
        send(3, 40);
        send(3, 39);
        send(12, 100);
        send(15, -7);
        setcfg(-128, 1'b1, 0);
        send(0, -128);
        idle(2);
        setcfg(40, 1'b0, 0);
        cnt_clear = 1'b1;
        send(4, 50);
        cnt_clear = 1'b0;
        total++;
        if (spike_count !== 4'd1) begin
            bad++;
            $display("FAIL clear_with_spike: got %0d expected 1", spike_count);
        end
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        total++;
        if (spike_count !== 4'd0) begin
            bad++;
            $display("FAIL clear_only: got %0d expected 0", spike_count);
        end
        idle(1);
    endtask

    task automatic test_saturation();
        setcfg(0, 1'b0, 0);
        for (int i = 0; i < 18; i++) send(1, 100);
        idle(2);
        total++;
        if (spike_count !== 4'd15) begin
            bad++;
            $display("FAIL cnt_saturate: got %0d expected 15", spike_count);
        end
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 4) != 0);
            in_idx     = 4'($urandom_range(0, 11));
            in_vmem    = 8'($urandom_range(0, 255));
            vth        = 8'($urandom_range(0, 120) - 60);
            reset_mode = 1'($urandom_range(0, 1));
            ref_period = 4'($urandom_range(0, 3));
            cnt_clear  = ($urandom_range(0, 30) == 0);
            tick();
        end
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        idle(3);
    endtask

    task automatic test_async_reset();
        setcfg(40, 1'b0, 3);
        send(2, 50);
        out_ready = 1'b0;
        send(3, 60);
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_idx, vmem_out, spike_out, spike_count} !== 18'd0) begin
            bad++;
            $display("FAIL async_reset: got ov=%0b idx=%0d vmem=%0d spk=%0b cnt=%0d expected all zero",
                     out_valid, out_idx, vmem_out, spike_out, spike_count);
        end
        sbq.delete();
        foreach (m_ref[k]) m_ref[k] = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2, 40);
        send(3, 40);
        idle(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        vth        = 8'sd0;
        reset_mode = 1'b0;
        ref_period = 4'd0;
        in_valid   = 1'b0;
        in_idx     = 4'd0;
        in_vmem    = 8'sd0;
        out_ready  = 1'b1;
        cnt_clear  = 1'b0;
        foreach (m_ref[k]) m_ref[k] = 0;
        test_reset();
        test_basic();
        test_mode1();
        test_refractory();
        test_backpressure();
        test_boundaries();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding results expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threshold_refractory_unit.md
Name: threshold_refractory_unit

Overview:
Time-multiplexed spike/threshold stage for NUM_NEURONS neurons sharing one datapath. Accepts one (neuron index, membrane potential) sample per cycle over valid/ready. Compares the sample against a runtime threshold and applies a selectable reset mode and a per-neuron refractory period. Emits the updated potential and spike flag through a registered output stage. Sits between the leak/integrate accumulator and the spike router; it generalises the combinational threshold stage with state, handshakes and modes.

Parameters:
INTEGER_WIDTH, 8, integer bits of membrane potential
DATA_WIDTH_FRAC, 0, fractional bits of membrane potential
DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total signed potential width
NUM_NEURONS, 16, neurons served (>=2, need not be power of 2)
IDX_WIDTH, $clog2(NUM_NEURONS), neuron index width
REF_WIDTH, 4, refractory counter width
CNT_WIDTH, 16, spike counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
vth  in  DATA_WIDTH  signed threshold, sampled on accept
reset_mode  in  1  0 = reset-to-zero, 1 = subtract-threshold; sampled on accept
ref_period  in  REF_WIDTH  refractory length in accesses; 0 disables refractory
in_valid  in  1  input sample valid
in_ready  out  1  unit can accept
in_idx  in  IDX_WIDTH  neuron index
in_vmem  in  DATA_WIDTH  signed membrane potential
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_idx  out  IDX_WIDTH  neuron index of result
vmem_out  out  DATA_WIDTH  signed updated potential
spike_out  out  1  spike flag of result
cnt_clear  in  1  synchronous clear of spike_count
spike_count  out  CNT_WIDTH  total spikes emitted, saturating

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_idx=0, vmem_out=0, spike_out=0, spike_count=0, all ref_cnt[0..NUM_NEURONS-1]=0. Reset mid-transfer drops the held output; no replay.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: result registered 1 cycle after accept; full throughput of 1 sample/cycle with continuous out_ready.
- Output holds stable (idx, vmem_out, spike_out) while out_valid && !out_ready. out_valid clears on out_ready when there is no new accept.
- Per-accept decision for neuron i=in_idx, in priority order:
  1. i >= NUM_NEURONS: passthrough, vmem_out=in_vmem, spike=0, no state change.
  2. ref_cnt[i] != 0 (refractory): spike=0, vmem_out=0, ref_cnt[i] decrements by 1.
  3. in_vmem >= vth (signed compare): spike=1, ref_cnt[i]=ref_period. Mode 0: vmem_out=0. Mode 1: vmem_out=in_vmem-vth, computed at DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range.
  4. Otherwise: spike=0, vmem_out=in_vmem.
- Refractory counters advance only when their own neuron is accessed; other neurons are untouched.
- ref_period=0: a spike leaves ref_cnt[i]=0, so the neuron can fire again on its next access.
- spike_count increments on accept with spike=1 and saturates at 2^CNT_WIDTH-1. cnt_clear without a spike sets it to 0. cnt_clear and a spiking accept in the same cycle set it to 1.
- vth and reset_mode are sampled only at accept; changes while the output is stalled do not alter the held result.

Test Plan:
- Reset then idle: out_valid=0, spike_count=0, in_ready=1. Drive in_valid, idx=3, vmem=50, vth=40, mode 0, ref_period=0, out_ready=1 -> next cycle out_valid=1, spike=1, vmem_out=0, out_idx=3, spike_count=1.
- Mode 1, vth=40: vmem=100 -> vmem_out=60, spike=1. With vth=-100 and vmem=100 (8-bit) -> vmem_out saturates to 127.
- ref_period=2, idx=5 spikes with vmem=50, then accessed twice with vmem=120 -> two outputs spike=0, vmem_out=0. Third access with vmem=120 -> spike=1. idx=6 interleaved and unaffected.
- Backpressure: out_ready=0 for 3 cycles after an accept -> in_ready=0 and the output is held unchanged. Change vth during the stall -> held result unchanged. Release -> stream resumes with no loss or duplication.
- Boundaries: vmem == vth -> spike=1. vmem = vth-1 -> passthrough. NUM_NEURONS=10 with idx=12 -> passthrough, spike=0. cnt_clear coincident with a spike -> spike_count=1.
- Async reset asserted while out_valid=1, out_ready=0 -> outputs and counters zero immediately. Refractory state cleared, so the first post-reset access at threshold spikes.
